// File: rtl/gpio_ctrl_if.sv
// Simple CPU-side register bus between a bus master and the GPIO controller.
// One-cycle write/read strobes; read data returns registered with rd_valid.
interface gpio_ctrl_if #(
  parameter int NUM_IO = 8
);
  logic              wr_en;
  logic              rd_en;
  logic [2:0]        addr;
  logic [NUM_IO-1:0] wdata;
  logic [NUM_IO-1:0] rdata;
  logic              rd_valid;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, rd_valid
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO bank controller: direction/data registers driving the
// tristate pad buffers, synchronised readback, edge capture and a maskable irq.
module gpio_ctrl #(
  parameter int NUM_IO = 8
) (
  input  logic              clk,
  input  logic              rst,
  gpio_ctrl_if.slave        bus,
  output logic [NUM_IO-1:0] gpio_t,
  output logic [NUM_IO-1:0] gpio_o,
  input  logic [NUM_IO-1:0] gpio_i,
  output logic              irq
);

  typedef enum logic [2:0] {
    ADDR_DIR      = 3'd0,
    ADDR_DOUT     = 3'd1,
    ADDR_DIN      = 3'd2,
    ADDR_RISE_EN  = 3'd3,
    ADDR_FALL_EN  = 3'd4,
    ADDR_IRQ_STAT = 3'd5,
    ADDR_IRQ_MASK = 3'd6,
    ADDR_DOUT_TGL = 3'd7
  } reg_addr_e;

  reg_addr_e         addr;

  logic [NUM_IO-1:0] dir_q,     dir_d;
  logic [NUM_IO-1:0] dout_q,    dout_d;
  logic [NUM_IO-1:0] rise_en_q, rise_en_d;
  logic [NUM_IO-1:0] fall_en_q, fall_en_d;
  logic [NUM_IO-1:0] mask_q,    mask_d;
  logic [NUM_IO-1:0] stat_q,    stat_d;
  logic [NUM_IO-1:0] w1c;

  logic [NUM_IO-1:0] sync1_q, sync2_q, hist_q;
  logic [1:0]        warm_q;
  logic              edge_armed;
  logic [NUM_IO-1:0] rise, fall, stat_set;

  logic [NUM_IO-1:0] rd_mux;
  logic [NUM_IO-1:0] rdata_q;
  logic              rd_valid_q;
  logic              irq_q;

  assign addr = reg_addr_e'(bus.addr);

  // Register writes and the W1C clear mask for interrupt status.
  always_comb begin
    // NOTE: every comb output gets its hold value first so no path infers a latch.
    dir_d     = dir_q;
    dout_d    = dout_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    w1c       = '0;
    if (bus.wr_en) begin
      case (addr)
        ADDR_DIR:      dir_d     = bus.wdata;
        ADDR_DOUT:     dout_d    = bus.wdata;
        ADDR_RISE_EN:  rise_en_d = bus.wdata;
        ADDR_FALL_EN:  fall_en_d = bus.wdata;
        ADDR_IRQ_STAT: w1c       = bus.wdata;
        ADDR_IRQ_MASK: mask_d    = bus.wdata;
        ADDR_DOUT_TGL: dout_d    = dout_q ^ bus.wdata;
        default:       ;
      endcase
    end
  end

  // Edges are ignored until the history pipe has seen real pad samples.
  assign edge_armed = (warm_q == 2'd3);
  assign rise       = sync2_q & ~hist_q;
  assign fall       = ~sync2_q & hist_q;
  assign stat_set   = edge_armed ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
  // A new event outranks a simultaneous W1C so it is never lost.
  assign stat_d     = stat_set | (stat_q & ~w1c);

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DIR:      rd_mux = dir_q;
      ADDR_DOUT:     rd_mux = dout_q;
      ADDR_DIN:      rd_mux = sync2_q;
      ADDR_RISE_EN:  rd_mux = rise_en_q;
      ADDR_FALL_EN:  rd_mux = fall_en_q;
      ADDR_IRQ_STAT: rd_mux = stat_q;
      ADDR_IRQ_MASK: rd_mux = mask_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= '0;
      dout_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      mask_q     <= '0;
      stat_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      warm_q     <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; reads see pre-write state.
      dir_q      <= dir_d;
      dout_q     <= dout_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      mask_q     <= mask_d;
      stat_q     <= stat_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      if (!edge_armed) warm_q <= warm_q + 2'd1;
      if (bus.rd_en) rdata_q <= rd_mux;
      rd_valid_q <= bus.rd_en;
      irq_q      <= |(stat_q & mask_q);
    end
  end

  assign gpio_t       = ~dir_q;
  assign gpio_o       = dout_q;
  assign irq          = irq_q;
  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl: register map, pad drive,
// edge/interrupt timing, set-vs-W1C priority, warm-up and mid-read reset.
module tb_gpio_ctrl;
  localparam logic [2:0] A_DIR  = 3'd0, A_DOUT = 3'd1, A_DIN  = 3'd2, A_RISE = 3'd3,
                         A_FALL = 3'd4, A_STAT = 3'd5, A_MASK = 3'd6, A_TGL  = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_t, gpio_o, gpio_i;
  logic       irq;
  int         checks   = 0;
  int         failures = 0;

  gpio_ctrl_if #(.NUM_IO(8)) bus ();

  gpio_ctrl #(.NUM_IO(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .gpio_t (gpio_t),
    .gpio_o (gpio_o),
    .gpio_i (gpio_i),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    check(tag, {24'd0, bus.rdata}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    gpio_i = 8'h3C;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 3'd0; bus.wdata = 8'h00;

    // 1: reset state and read-back of every address
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gpio_t", {24'd0, gpio_t}, 32'hFF);
    check("rst_gpio_o", {24'd0, gpio_o}, 32'h00);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_rdata", {24'd0, bus.rdata}, 32'h00);
    rst = 1'b0;
    idle();
    check("idle_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    read_chk(A_DIR,  8'h00, "rd_dir");
    read_chk(A_DOUT, 8'h00, "rd_dout");
    read_chk(A_DIN,  8'h3C, "rd_din");
    read_chk(A_RISE, 8'h00, "rd_rise");
    read_chk(A_FALL, 8'h00, "rd_fall");
    read_chk(A_STAT, 8'h00, "rd_stat");
    read_chk(A_MASK, 8'h00, "rd_mask");
    read_chk(A_TGL,  8'h00, "rd_tgl");
    idle();
    check("rd_valid_single", {31'd0, bus.rd_valid}, 32'd0);

    // 2: direction, data and toggle
    write(A_DIR, 8'h0F);
    check("dir_gpio_t", {24'd0, gpio_t}, 32'hF0);
    write(A_DOUT, 8'hA5);
    check("dout_gpio_o", {24'd0, gpio_o}, 32'hA5);
    write(A_TGL, 8'hFF);
    check("tgl_gpio_o", {24'd0, gpio_o}, 32'h5A);
    read_chk(A_DOUT, 8'h5A, "rd_dout_tgl");
    read_chk(A_TGL,  8'h00, "rd_tgl_zero");
    write(A_DIN, 8'hFF);
    read_chk(A_DIN,  8'h3C, "din_ro");
    // Simultaneous read and write returns the pre-write value
    @(negedge clk);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = A_DOUT; bus.wdata = 8'h33;
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    check("rw_rdata", {24'd0, bus.rdata}, 32'h5A);
    check("rw_gpio_o", {24'd0, gpio_o}, 32'h33);
    write(A_DIR, 8'h00);
    check("release_gpio_t", {24'd0, gpio_t}, 32'hFF);
    check("release_gpio_o", {24'd0, gpio_o}, 32'h33);

    // 3: rising edge on pad 0, exact latency, W1C
    @(negedge clk); gpio_i = 8'h00;
    repeat (4) idle();
    write(A_RISE, 8'h01);
    write(A_MASK, 8'h01);
    @(negedge clk); gpio_i = 8'h01;
    idle();
    check("rise_irq_k", {31'd0, irq}, 32'd0);
    idle();
    check("rise_irq_k1", {31'd0, irq}, 32'd0);
    read_chk(A_STAT, 8'h00, "rise_stat_k2_pre");
    check("rise_irq_k2", {31'd0, irq}, 32'd0);
    read_chk(A_STAT, 8'h01, "rise_stat_set");
    check("rise_irq_k3", {31'd0, irq}, 32'd1);
    write(A_STAT, 8'h01);
    check("w1c_irq_same", {31'd0, irq}, 32'd1);
    idle();
    check("w1c_irq_next", {31'd0, irq}, 32'd0);
    read_chk(A_STAT, 8'h00, "w1c_stat");

    // 4: falling edge on pad 1 latched while masked
    write(A_MASK, 8'h00);
    write(A_FALL, 8'h02);
    @(negedge clk); gpio_i = 8'h03;
    repeat (4) idle();
    @(negedge clk); gpio_i = 8'h01;
    repeat (4) idle();
    read_chk(A_STAT, 8'h02, "fall_stat");
    check("fall_irq_masked", {31'd0, irq}, 32'd0);
    write(A_MASK, 8'h02);
    check("unmask_irq_same", {31'd0, irq}, 32'd0);
    idle();
    check("unmask_irq_next", {31'd0, irq}, 32'd1);
    write(A_STAT, 8'h02);
    idle();
    check("fall_w1c_irq", {31'd0, irq}, 32'd0);

    // 5: set and W1C on the same edge, set wins
    @(negedge clk); gpio_i = 8'h00;
    repeat (4) idle();
    read_chk(A_STAT, 8'h00, "pre_race_stat");
    @(negedge clk); gpio_i = 8'h01;
    idle();
    idle();
    write(A_STAT, 8'h01);
    read_chk(A_STAT, 8'h01, "race_stat");
    check("race_irq_masked", {31'd0, irq}, 32'd0);

    // 6: pads high through reset, warm-up suppresses the false rise
    @(negedge clk); gpio_i = 8'hFF; rst = 1'b1;
    repeat (2) idle();
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.addr = A_RISE; bus.wdata = 8'hFF;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    write(A_MASK, 8'hFF);
    repeat (6) idle();
    read_chk(A_STAT, 8'h00, "warmup_stat");
    check("warmup_irq", {31'd0, irq}, 32'd0);
    read_chk(A_DIN, 8'hFF, "warmup_din");

    // Reset during a read drops the pending rd_valid and clears everything
    write(A_DIR, 8'hFF);
    write(A_DOUT, 8'h81);
    check("pre_rst_gpio_t", {24'd0, gpio_t}, 32'h00);
    check("pre_rst_gpio_o", {24'd0, gpio_o}, 32'h81);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = A_DIN;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    check("midrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("midrst_rdata", {24'd0, bus.rdata}, 32'h00);
    check("midrst_gpio_t", {24'd0, gpio_t}, 32'hFF);
    check("midrst_gpio_o", {24'd0, gpio_o}, 32'h00);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    idle();
    check("midrst_rd_valid2", {31'd0, bus.rd_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    idle();
    check("postrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    read_chk(A_DIR,  8'h00, "postrst_dir");
    read_chk(A_DOUT, 8'h00, "postrst_dout");
    read_chk(A_RISE, 8'h00, "postrst_rise");
    read_chk(A_FALL, 8'h00, "postrst_fall");
    read_chk(A_STAT, 8'h00, "postrst_stat");
    read_chk(A_MASK, 8'h00, "postrst_mask");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Register-mapped controller for a bank of bidirectional GPIO pads built from our per-bit tristate pad buffers (T high = pad released/high-Z, I = drive value, O = pad readback).
- Owns direction and output-data registers and drives the buffer T/I vectors.
- Synchronises pad readback, detects edges, latches interrupt status and raises a single maskable interrupt.
- Sits between the CPU-side simple register bus and the pad buffer instance.

Parameters:
NUM_IO, 8, number of GPIO bits (1..32); all data registers are NUM_IO wide.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  register write strobe, one cycle per write
rd_en  input  1  register read strobe, one cycle per read
addr  input  3  register index
wdata  input  NUM_IO  write data
rdata  output  NUM_IO  read data, registered
rd_valid  output  1  one-cycle pulse, rdata valid
gpio_t  output  NUM_IO  to pad buffer Ts; 1 = high-Z
gpio_o  output  NUM_IO  to pad buffer Is; drive value
gpio_i  input  NUM_IO  from pad buffer Os; asynchronous pad level
irq  output  1  level interrupt, registered

Behaviour:
- Reset (async assert, sync-released logic):
  - all registers 0; gpio_t = all 1 (every pad input); gpio_o = 0; rdata = 0; rd_valid = 0; irq = 0.
  - sync/history flops = 0; warm-up counter = 0.
- Register map:
  - 0 DIR (RW): 1 = output. gpio_t = ~DIR.
  - 1 DOUT (RW): gpio_o = DOUT, driven regardless of DIR.
  - 2 DIN (RO): synchronised pad level; writes ignored.
  - 3 RISE_EN (RW).
  - 4 FALL_EN (RW).
  - 5 IRQ_STAT (R/W1C).
  - 6 IRQ_MASK (RW).
  - 7 DOUT_TGL (WO): DOUT <= DOUT ^ wdata; reads return 0.
- Writes take effect at the clock edge where wr_en = 1; gpio_t/gpio_o change on that same edge (registered outputs, no combinational path from the bus).
- Reads:
  - rdata and rd_valid are registered one cycle after rd_en.
  - rd_en and wr_en in the same cycle are legal; the read returns the pre-write value.
  - rd_en on consecutive cycles gives consecutive rd_valid pulses.
- Input path:
  - Two-flop synchroniser s1 -> s2, then history flop s3.
  - DIN = s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Edge detection is suppressed until a 2-bit warm-up counter saturates at 3, i.e. for the first 3 clocks after reset release. This prevents a pad held high at reset from being reported as a rising edge.
- IRQ_STAT update, per bit each clock:
  - set if (rise & RISE_EN) | (fall & FALL_EN);
  - else cleared if W1C write with wdata bit = 1.
  - Set and W1C in the same cycle on the same bit: set wins (event not lost).
- Status latches even when IRQ_MASK bit = 0; masking only gates irq.
- irq <= |(IRQ_STAT & IRQ_MASK), registered.
- Latency: pad change first sampled at edge k -> s2 at k+1 -> IRQ_STAT set at k+2 -> irq at k+3.
- Pads pulsing shorter than one clock may be missed; this is not guaranteed.
- Writing DIR from 1 to 0 releases the pad but preserves DOUT.
- Reset asserted mid-operation: all state clears immediately; a pending rd_valid is dropped; the warm-up is re-applied.
- NUM_IO < 32: unused wdata bits do not exist; addr is always 3 bits.

Test Plan:
1. Reset, read all 8 addresses -> rdata = 0 except DIN = pad level; gpio_t = all 1; irq = 0; rd_valid exactly 1 cycle after each rd_en.
2. Write DIR = 0x0F, DOUT = 0xA5, then DOUT_TGL = 0xFF -> gpio_t = 0xF0, gpio_o = 0x5A on the write edge; DOUT readback 0x5A, DOUT_TGL read 0.
3. RISE_EN = 0x01, IRQ_MASK = 0x01, pad 0 goes 0->1 -> IRQ_STAT = 0x01 two clocks after first sample, irq = 1 one clock later; W1C 0x01 -> IRQ_STAT = 0, irq = 0 next clock.
4. FALL_EN = 0x02, IRQ_MASK = 0; pad 1 goes 1->0 -> IRQ_STAT = 0x02, irq stays 0; set IRQ_MASK = 0x02 -> irq = 1 next clock.
5. Time a pad 0 rising edge so IRQ_STAT sets in the same cycle as a W1C 0x01 -> IRQ_STAT bit 0 remains 1.
6. Hold gpio_i = 0xFF through reset with RISE_EN written to 0xFF on the first post-reset cycle -> no IRQ_STAT bits set. Then assert rst mid-read -> rd_valid never pulses, all registers are 0, gpio_t = all 1.
